// File: rtl/delta_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : delta_result_buffer
// Brief    : Change-detecting result buffer. Pushes result_in into a
//            first-word-fall-through FIFO only when it differs from the last
//            sampled value, and counts change events lost to a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module delta_result_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       sample_en,
    input  logic [WIDTH-1:0]           result_in,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]     c_LVL_ONE = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]   c_PTR_ONE = c_AW'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic [CNT_W-1:0] r_drop_count;
    logic [WIDTH-1:0] r_last_val;
    logic             r_last_vld;

    logic w_change;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Event decode: change detection, pop/push qualification and drop.
    // A full FIFO still accepts a push when the head is popped the same cycle.
    always_comb begin
        w_change = sample_en && (!r_last_vld || (result_in != r_last_val));
        w_pop    = (r_level != '0) && out_ready;
        w_push   = w_change && ((r_level != c_FULL) || w_pop);
        w_drop   = w_change && !w_push;
    end

    // Control state: pointers, occupancy, drop counter and change tracking.
    // clear wins over everything and leaves last_val untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= '0;
            r_last_val   <= '0;
            r_last_vld   <= 1'b0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= '0;
            r_last_vld   <= 1'b0;
        end else begin
            if (sample_en) begin
                r_last_val <= result_in;
                r_last_vld <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_count != c_CNT_MAX)) begin
                r_drop_count <= r_drop_count + c_CNT_ONE;
            end
        end
    end

    // Storage write; array contents are never reset, only pointers are.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= result_in;
        end
    end

    assign out_data   = r_mem[r_rd_ptr];
    assign out_valid  = (r_level != '0);
    assign level      = r_level;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_delta_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_delta_result_buffer
// Brief    : Directed self-checking bench for delta_result_buffer. A second
//            instance with a 2-bit drop counter shares the stimulus so that
//            counter saturation can be observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delta_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        sample_en;
    logic [15:0] result_in;
    logic        out_ready;

    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  level;
    logic [7:0]  drop_count;

    logic [15:0] out_data_s;
    logic        out_valid_s;
    logic [2:0]  level_s;
    logic [1:0]  drop_count_s;

    int checks   = 0;
    int failures = 0;

    delta_result_buffer #(.WIDTH(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sample_en  (sample_en),
        .result_in  (result_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .drop_count (drop_count)
    );

    delta_result_buffer #(.WIDTH(16), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sample_en  (sample_en),
        .result_in  (result_in),
        .out_data   (out_data_s),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .level      (level_s),
        .drop_count (drop_count_s)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [15:0] v);
        sample_en = 1'b1;
        result_in = v;
        tick();
    endtask

    // Directed sequence.
    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        sample_en = 1'b0;
        result_in = '0;
        out_ready = 1'b0;
        #2;
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Repeated value suppressed, first sample always a change.
        out_ready = 1'b1;
        sample(16'h0000);
        chk("s1_first_valid", 32'(out_valid), 32'd1);
        chk("s1_first_data", 32'(out_data), 32'h0000);
        chk("s1_first_level", 32'(level), 32'd1);
        sample(16'h0000);
        chk("s1_dup_valid", 32'(out_valid), 32'd0);
        chk("s1_dup_level", 32'(level), 32'd0);
        sample(16'h0005);
        chk("s1_second_valid", 32'(out_valid), 32'd1);
        chk("s1_second_data", 32'(out_data), 32'h0005);
        sample_en = 1'b0;
        tick();
        chk("s1_drained_level", 32'(level), 32'd0);
        chk("s1_drop", 32'(drop_count), 32'd0);

        // Stalled consumer, six distinct samples: four stored, two dropped.
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            sample(16'(k));
        end
        chk("s2_level_full", 32'(level), 32'd4);
        chk("s2_drop", 32'(drop_count), 32'd2);
        sample_en = 1'b0;
        tick();
        chk("s2_stall_data", 32'(out_data), 32'h0001);
        chk("s2_stall_level", 32'(level), 32'd4);

        // Full FIFO with a pop in the same cycle accepts the new sample.
        out_ready = 1'b1;
        chk("s3_head_before", 32'(out_data), 32'h0001);
        sample(16'h0007);
        chk("s3_level", 32'(level), 32'd4);
        chk("s3_drop", 32'(drop_count), 32'd2);
        sample_en = 1'b0;
        chk("s3_read2", 32'(out_data), 32'h0002);
        tick();
        chk("s3_read3", 32'(out_data), 32'h0003);
        tick();
        chk("s3_read4", 32'(out_data), 32'h0004);
        tick();
        chk("s3_read7", 32'(out_data), 32'h0007);
        tick();
        chk("s3_empty", 32'(out_valid), 32'd0);

        // Drop counter saturation on the 2-bit instance.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_drop", 32'(drop_count), 32'd0);
        chk("clr_drop_sat", 32'(drop_count_s), 32'd0);
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            sample(16'h0010 + 16'(k));
        end
        chk("s4_drop_wide", 32'(drop_count), 32'd5);
        chk("s4_drop_sat", 32'(drop_count_s), 32'd3);
        chk("s4_level_sat", 32'(level_s), 32'd4);

        // Clear with a concurrent sample, then resample the prior value.
        clear = 1'b1;
        sample_en = 1'b0;
        tick();
        clear = 1'b0;
        sample(16'h0021);
        sample(16'h0022);
        sample(16'h0023);
        chk("s5_level3", 32'(level), 32'd3);
        clear = 1'b1;
        sample(16'h0024);
        clear = 1'b0;
        chk("s5_clr_level", 32'(level), 32'd0);
        chk("s5_clr_valid", 32'(out_valid), 32'd0);
        sample(16'h0023);
        chk("s5_resample_level", 32'(level), 32'd1);
        chk("s5_resample_data", 32'(out_data), 32'h0023);

        // Asynchronous reset between edges.
        sample(16'h0030);
        sample_en = 1'b0;
        chk("s6_level2", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_valid", 32'(out_valid), 32'd0);
        chk("s6_async_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        tick();
        sample(16'h0000);
        chk("s6_post_reset_push", 32'(level), 32'd1);
        chk("s6_post_reset_data", 32'(out_data), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delta_result_buffer.md
DELTA_RESULT_BUFFER -- requirements
Module: delta_result_buffer

Interface
REQ-001 Parameter WIDTH SHALL default to 16; it sets the result sample width.
REQ-002 Parameter DEPTH SHALL default to 4; it sets the FIFO entry count and SHALL be a power of two, 2 or greater.
REQ-003 Parameter CNT_W SHALL default to 8; it sets the drop counter width.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous flush of all state.
REQ-007 sample_en  input  1  qualifies result_in this cycle.
REQ-008 result_in  input  WIDTH  result word from the upstream delta stage.
REQ-009 out_data  output  WIDTH  head-of-FIFO word.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  consumer accepts the head word.
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 drop_count  output  CNT_W  count of change events lost because the FIFO was full, saturating.

Function
REQ-014 The block SHALL hold last_val (WIDTH bits) and last_vld (1 bit) for change detection.
REQ-015 A change event SHALL occur when sample_en=1 AND (last_vld=0 OR result_in!=last_val).
REQ-016 On every sample_en=1 cycle, the block SHALL load last_val<=result_in and set last_vld<=1, whether or not a change event occurred.
REQ-017 A sample with sample_en=1 that equals last_val while last_vld=1 SHALL NOT push and SHALL NOT count as a drop.
REQ-018 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 A push SHALL occur on a change event when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-020 A change event that does not push SHALL increment drop_count by 1, saturating at 2^CNT_W-1.
REQ-021 The FIFO SHALL be first-word-fall-through: out_data = oldest entry, and out_valid = (level!=0).
REQ-022 Latency: a word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 on the next cycle.
REQ-023 Simultaneous push and pop SHALL leave level unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 When out_valid=0, out_data value SHALL be don't-care, and out_ready SHALL have no effect.
REQ-026 clear=1 SHALL, at the next edge, set level to 0, empty the FIFO, set last_vld to 0 and set drop_count to 0.
REQ-027 clear SHALL override any push, pop or drop in the same cycle; the word on result_in that cycle SHALL be discarded and SHALL NOT update last_val.
REQ-028 level SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force level=0, out_valid=0, drop_count=0, last_vld=0, last_val=0, and both FIFO pointers to 0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered words.
REQ-031 Storage array contents need not be reset.
REQ-032 After rst_n deasserts, the first sample_en=1 cycle SHALL always produce a change event.

Verification
REQ-033 Scenario: after reset, sample_en=1 with result_in 0x0000, 0x0000, 0x0005 on consecutive cycles, out_ready=1 -> the bench observes exactly two outputs, 0x0000 then 0x0005; drop_count=0.
REQ-034 Scenario: out_ready=0, six distinct samples 0x1..0x6 -> level=4 and drop_count=2; then out_ready=1 -> the bench reads 0x1, 0x2, 0x3, 0x4 in order.
REQ-035 Scenario: FIFO full, out_ready=1, new distinct sample in the same cycle -> the sample is accepted, level stays 4 and drop_count is unchanged.
REQ-036 Scenario: with CNT_W=2 and a full, stalled FIFO, five distinct samples -> drop_count saturates at 3.
REQ-037 Scenario: level=3 and clear=1 together with a distinct sample -> next cycle level=0 and out_valid=0; re-sampling the prior last_val value then pushes it, because last_vld was cleared.
REQ-038 Scenario: rst_n pulsed low between clock edges while level=2 -> out_valid=0 and level=0 before the next edge.
